// File: rtl/herald_host_driver_if.sv
// herald_host_driver_if: request/response port and byte-wide strobe bus of the Herald host driver
interface herald_host_driver_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [15:0] req_opa;
    logic [15:0] req_opb;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [7:0]  bus_out;
    logic        wr_strobe;
    logic        rd_strobe;
    logic [7:0]  bus_in;
    logic        active;
    modport master (
        input  req_valid, req_cmd, req_opa, req_opb, bus_in,
        output req_ready, rsp_valid, rsp_data, rsp_err, bus_out, wr_strobe, rd_strobe, active
    );
    modport slave (
        output req_valid, req_cmd, req_opa, req_opb, bus_in,
        input  req_ready, rsp_valid, rsp_data, rsp_err, bus_out, wr_strobe, rd_strobe, active
    );
endinterface

// File: rtl/herald_host_driver.sv
// herald_host_driver: serialises one command onto the Herald strobe bus and collects its result bytes
module herald_host_driver #(
    parameter int STROBE_HI     = 2,
    parameter int STROBE_LO     = 2,
    parameter int RD_SAMPLE_DLY = 2,
    parameter int TIMEOUT       = 1023
) (
    input logic clk,
    input logic rst,
    herald_host_driver_if.master hif
);
    typedef enum logic [3:0] {
        IDLE, WR_SETUP, WR_HI, WR_LO, WAIT_BUSY_HI, WAIT_BUSY_LO, RD_HI, RD_LO, RESPOND
    } state_t;
    localparam int CW = $clog2(TIMEOUT + STROBE_HI + STROBE_LO + 2);
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [15:0] opa_q, opb_q;
    logic [2:0] nw, nr, wi, nw_d, nr_d;
    logic [1:0] rc;
    logic [31:0] data_q;
    logic err_q;
    logic [7:0] out_q, wbyte;
    logic accept, busy, tmo, hi_done, lo_done, samp, tmo_evt;
    assign accept  = hif.req_valid && state == IDLE;
    assign busy    = hif.bus_in[7];
    assign tmo     = cnt == CW'(TIMEOUT);
    assign hi_done = cnt == CW'(STROBE_HI - 1);
    assign lo_done = cnt == CW'(STROBE_LO - 1);
    assign nw_d = hif.req_cmd == 8'h10 ? 3'd3 :
                  (hif.req_cmd inside {8'h11, 8'h12, 8'h20, 8'h21}) ? 3'd5 :
                  hif.req_cmd == 8'h22 ? 3'd1 : 3'd0;
    assign nr_d = hif.req_cmd == 8'h10 ? 3'd4 :
                  (hif.req_cmd inside {8'h11, 8'h12, 8'h20, 8'h21}) ? 3'd2 : 3'd0;
    // the command byte is loaded straight from the request, so wi indexes operand bytes 1..4
    assign wbyte = wi == 3'd1 ? opa_q[7:0] : wi == 3'd2 ? opa_q[15:8] : wi == 3'd3 ? opb_q[7:0] : opb_q[15:8];
    // the peripheral shows each read byte for a single cycle, RD_SAMPLE_DLY edges after rd rises
    assign samp = (state == RD_HI && cnt == CW'(RD_SAMPLE_DLY - 1)) ||
                  (RD_SAMPLE_DLY > STROBE_HI && state == RD_LO && cnt == CW'(RD_SAMPLE_DLY - 1 - STROBE_HI));
    assign tmo_evt = tmo && ((state == WAIT_BUSY_HI && !busy) || (state == WAIT_BUSY_LO && busy));
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:         if (accept) nxt = nw_d == 3'd0 ? RESPOND : WR_SETUP;
            WR_SETUP:     nxt = WR_HI;
            WR_HI:        if (hi_done) nxt = WR_LO;
            WR_LO:        if (lo_done) nxt = wi == 3'd1 ? WAIT_BUSY_HI : wi < nw ? WR_SETUP : WAIT_BUSY_LO;
            WAIT_BUSY_HI: if (busy) nxt = wi < nw ? WR_SETUP : WAIT_BUSY_LO; else if (tmo) nxt = RESPOND;
            WAIT_BUSY_LO: if (!busy) nxt = nr == 3'd0 ? RESPOND : RD_HI; else if (tmo) nxt = RESPOND;
            RD_HI:        if (hi_done) nxt = RD_LO;
            RD_LO:        if (lo_done) nxt = {1'b0, rc} + 3'd1 < nr ? RD_HI : RESPOND;
            RESPOND:      nxt = IDLE;
            default:      nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            nw     <= '0;
            nr     <= '0;
            wi     <= '0;
            rc     <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            out_q  <= '0;
        end else begin
            state <= nxt;
            cnt   <= nxt == state ? cnt + CW'(1) : '0;
            if (accept) begin
                opa_q  <= hif.req_opa;
                opb_q  <= hif.req_opb;
                nw     <= nw_d;
                nr     <= nr_d;
                wi     <= nw_d != 3'd0 ? 3'd1 : 3'd0;
                rc     <= '0;
                data_q <= '0;
                err_q  <= nw_d == 3'd0;
                if (nw_d != 3'd0) out_q <= hif.req_cmd;
            end else if (nxt == WR_SETUP) begin
                out_q <= wbyte;
                wi    <= wi + 3'd1;
            end
            if (samp) data_q[{rc, 3'b000} +: 8] <= hif.bus_in;
            if (state == RD_LO && lo_done) rc <= rc + 2'd1;
            if (tmo_evt) begin
                err_q  <= 1'b1;
                data_q <= '0;
            end
        end
    end
    assign hif.req_ready = state == IDLE;
    assign hif.active    = state != IDLE;
    assign hif.rsp_valid = state == RESPOND;
    assign hif.wr_strobe = state == WR_HI;
    assign hif.rd_strobe = state == RD_HI;
    assign hif.rsp_data  = data_q;
    assign hif.rsp_err   = err_q;
    assign hif.bus_out   = out_q;
endmodule

// File: tb/tb_herald_host_driver.sv
// tb_herald_host_driver: directed and random transactions against a behavioural Herald peripheral model
module tb_herald_host_driver;
    localparam int HI = 2, LO = 2, DLY = 3, TO = 40;
    logic clk = 1'b0, rst = 1'b1;
    herald_host_driver_if hif();
    herald_host_driver #(.STROBE_HI(HI), .STROBE_LO(LO), .RD_SAMPLE_DLY(DLY), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .hif(hif)
    );
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, nwr = 0, nw_m = 0, up_at = -1, dn_at = -1, rdk = -1;
    int wr_fall_cyc = 0, rsp_cyc = 0, viol = 0, mode = 0;
    bit busy = 0, wr_prev = 0, rd_prev = 0;
    logic [7:0] held;
    logic [7:0] wr_log[$];
    logic [7:0] rd_q[$];

    function automatic int ref_nw(input logic [7:0] c);
        if (c == 8'h10) return 3;
        if (c == 8'h11 || c == 8'h12 || c == 8'h20 || c == 8'h21) return 5;
        if (c == 8'h22) return 1;
        return 0;
    endfunction

    function automatic int ref_nr(input logic [7:0] c);
        if (c == 8'h10) return 4;
        if (c == 8'h11 || c == 8'h12 || c == 8'h20 || c == 8'h21) return 2;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // peripheral: BUSY rises after the command byte, falls after the last byte (mode 0),
    // stays high forever (mode 1) or never rises (mode 2); read bytes appear for one cycle only
    initial begin
        hif.bus_in = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                busy = 0; nwr = 0; up_at = -1; dn_at = -1; rdk = -1;
                hif.bus_in = 8'h00;
            end else begin
                if (hif.wr_strobe && !wr_prev) begin
                    wr_log.push_back(hif.bus_out);
                    held = hif.bus_out;
                    wr_cnt++;
                    nwr++;
                    if (nwr == 1) begin
                        nw_m = ref_nw(hif.bus_out);
                        if (mode != 2) up_at = cyc + int'($urandom_range(1, 6));
                    end
                    if (nwr == nw_m && mode == 0)
                        dn_at = (up_at > cyc + HI + LO ? up_at : cyc + HI + LO) + int'($urandom_range(1, 6));
                end
                if (hif.wr_strobe && wr_prev && hif.bus_out !== held) viol++;
                if (!hif.wr_strobe && wr_prev) wr_fall_cyc = cyc;
                if (hif.wr_strobe && hif.rd_strobe) viol++;
                if (hif.rd_strobe && !rd_prev) begin
                    rd_cnt++;
                    rdk = 0;
                end else if (rdk >= 0) rdk = rdk + 1 >= HI + LO ? -1 : rdk + 1;
                if (cyc == up_at) busy = 1;
                if (cyc == dn_at) busy = 0;
                if (hif.rsp_valid) begin
                    rsp_cyc = cyc; nwr = 0; busy = 0; up_at = -1; dn_at = -1;
                end
                if (rdk == DLY - 1) hif.bus_in = rd_q.size() > 0 ? rd_q.pop_front() : 8'hEE;
                else if (rdk >= 0) hif.bus_in = 8'($urandom);
                else hif.bus_in = {busy, 7'($urandom)};
            end
            wr_prev = hif.wr_strobe;
            rd_prev = hif.rd_strobe;
        end
    end

    task automatic do_txn(input logic [7:0] cmd, input logic [15:0] opa, input logic [15:0] opb,
                          input logic [31:0] rb, input int md);
        int nw, nr, ew, w0, r0, i;
        logic [7:0] exp_b[5];
        logic [31:0] exp_d;
        logic exp_e;
        nw = ref_nw(cmd);
        nr = ref_nr(cmd);
        exp_b[0] = cmd; exp_b[1] = opa[7:0]; exp_b[2] = opa[15:8]; exp_b[3] = opb[7:0]; exp_b[4] = opb[15:8];
        exp_e = nw == 0 || md != 0;
        ew = nw == 0 ? 0 : md == 2 ? 1 : nw;
        exp_d = '0;
        if (!exp_e) for (int k = 0; k < nr; k++) exp_d[8*k +: 8] = rb[8*k +: 8];
        @(negedge clk);
        mode = md;
        rd_q.delete();
        wr_log.delete();
        for (int k = 0; k < nr; k++) rd_q.push_back(rb[8*k +: 8]);
        w0 = wr_cnt;
        r0 = rd_cnt;
        hif.req_valid = 1'b1;
        hif.req_cmd = cmd;
        hif.req_opa = opa;
        hif.req_opb = opb;
        @(negedge clk);
        chk("req_ready_drop", {31'd0, hif.req_ready}, 32'd0);
        if (nw == 0) begin
            hif.req_valid = 1'b0;
            chk("unknown_rsp_next_cycle", {31'd0, hif.rsp_valid}, 32'd1);
        end else begin
            // a request held during the transaction must be ignored
            hif.req_cmd = 8'h10;
            hif.req_opa = 16'hFFFF;
            repeat (2) @(negedge clk);
            hif.req_valid = 1'b0;
            for (i = 0; i < 3000 && !hif.rsp_valid; i++) @(negedge clk);
            chk("rsp_seen", {31'd0, hif.rsp_valid}, 32'd1);
        end
        chk("rsp_err", {31'd0, hif.rsp_err}, {31'd0, exp_e});
        chk("rsp_data", hif.rsp_data, exp_d);
        chk("wr_count", wr_cnt - w0, ew);
        for (int k = 0; k < ew && k < wr_log.size(); k++) chk("wr_byte", {24'd0, wr_log[k]}, {24'd0, exp_b[k]});
        chk("rd_count", rd_cnt - r0, md == 0 ? nr : 0);
        if (md != 0 && nw != 0) chk("timeout_latency", rsp_cyc - wr_fall_cyc, LO + TO + 1);
        chk("bus_protocol", viol, 0);
        @(negedge clk);
        chk("ready_back", {31'd0, hif.req_ready}, 32'd1);
        chk("rsp_one_cycle", {31'd0, hif.rsp_valid}, 32'd0);
        chk("rsp_hold", hif.rsp_data, exp_d);
    endtask

    initial begin
        int i, w0, sel;
        logic [7:0] c;
        hif.req_valid = 1'b0;
        hif.req_cmd = 8'h00;
        hif.req_opa = 16'h0000;
        hif.req_opb = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, hif.req_ready}, 32'd1);
        chk("rst_idle", {28'd0, hif.rsp_valid, hif.rsp_err, hif.wr_strobe, hif.rd_strobe}, 32'd0);
        chk("rst_data", hif.rsp_data, 32'd0);
        chk("rst_bus_active", {23'd0, hif.active, hif.bus_out}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // reset while the opa MSB write strobe is high
        mode = 0;
        w0 = wr_cnt;
        hif.req_valid = 1'b1;
        hif.req_cmd = 8'h20;
        hif.req_opa = 16'h0180;
        hif.req_opb = 16'h0200;
        @(negedge clk);
        hif.req_valid = 1'b0;
        for (i = 0; i < 500 && !(wr_cnt - w0 == 3 && hif.wr_strobe); i++) @(negedge clk);
        chk("mid_wr_opa_msb", {23'd0, hif.wr_strobe, hif.bus_out}, 32'h101);
        rst = 1'b1;
        #1;
        chk("async_rst_strobes", {30'd0, hif.wr_strobe, hif.rd_strobe}, 32'd0);
        @(negedge clk);
        chk("rst_abort_bus", {22'd0, hif.wr_strobe, hif.rd_strobe, hif.bus_out}, 32'd0);
        chk("rst_abort_ready", {30'd0, hif.req_ready, hif.rsp_valid}, 32'd2);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_txn(8'h20, 16'h0180, 16'h0200, 32'h0000_0300, 0);
        do_txn(8'h10, 16'h0000, 16'h0000, 32'h0000_0100, 0);
        do_txn(8'h22, 16'h1234, 16'h5678, 32'h0, 0);
        do_txn(8'h55, 16'h1111, 16'h2222, 32'h0, 0);
        do_txn(8'h21, 16'h0A0B, 16'h0C0D, 32'h0000_BEEF, 1);
        do_txn(8'h11, 16'h0102, 16'h0304, 32'h0000_CAFE, 2);
        for (int n = 0; n < 12; n++) begin
            sel = int'($urandom_range(0, 6));
            c = sel == 0 ? 8'h10 : sel == 1 ? 8'h11 : sel == 2 ? 8'h12 : sel == 3 ? 8'h20 :
                sel == 4 ? 8'h21 : sel == 5 ? 8'h22 : 8'h30 + 8'($urandom_range(0, 8'hCF));
            do_txn(c, 16'($urandom), 16'($urandom), $urandom, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/herald_host_driver.md
Name: herald_host_driver

Overview:
- Host-side initiator for the Herald CORDIC/MAC peripheral's byte-wide strobe bus.
- Accepts one command transaction on a valid/ready request port. Serialises the command byte and operands onto the peripheral data bus using WR strobes.
- Waits on the peripheral's BUSY flag, then collects the result bytes using RD strobes and returns them on a response port.
- Used in the test harness and in FPGA bring-up builds, running in the same clock domain as the peripheral.

Parameters:
- STROBE_HI, default 2: cycles each WR/RD strobe is held high (minimum 1).
- STROBE_LO, default 2: minimum low cycles between strobes (minimum 1).
- RD_SAMPLE_DLY, default 2: cycles from RD rising to sampling bus_in. Must be ≤ STROBE_HI + STROBE_LO.
- TIMEOUT, default 1023: maximum cycles spent in any BUSY wait state.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high when the driver can accept a request.
- req_cmd  in  8  command code.
- req_opa  in  16  operand A (Q8.8).
- req_opb  in  16  operand B (Q8.8).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  32  result, little-endian byte assembly, zero-extended.
- rsp_err  out  1  qualifies rsp_valid: 1 means unknown command or timeout.
- bus_out  out  8  drives the peripheral data input.
- wr_strobe  out  1  drives peripheral WR (uio bit 0).
- rd_strobe  out  1  drives peripheral RD (uio bit 1).
- bus_in  in  8  peripheral data output; bit 7 is BUSY outside read windows.
- active  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, bus_out=0, wr_strobe=0, rd_strobe=0, active=0.
- Reset mid-transaction: abort immediately and drive strobes low. The peripheral must be reset alongside.
- Request acceptance: a request is accepted on the cycle req_valid && req_ready. The driver latches cmd, opa and opb, and req_ready drops the next cycle.
- Command table, write bytes / read bytes:
  - 0x10: 3 write (cmd, opa LSB, opa MSB) / 4 read.
  - 0x11, 0x12, 0x20, 0x21: 5 write (cmd, opa LSB, opa MSB, opb LSB, opb MSB) / 2 read.
  - 0x22: 1 write (cmd) / 0 read.
  - Any other code: no bus activity; rsp_valid=1 and rsp_err=1 one cycle after acceptance.
- States: IDLE → WR_SETUP → WR_HI → WR_LO → WAIT_BUSY_HI → (more bytes: WR_SETUP) → WAIT_BUSY_LO → RD_HI → RD_LO → RESPOND → IDLE.
- Write byte sequence:
  - WR_SETUP (1 cycle): bus_out takes the next byte.
  - WR_HI: wr_strobe=1 for STROBE_HI cycles.
  - WR_LO: wr_strobe=0 for STROBE_LO cycles.
  - bus_out changes only in WR_SETUP, never while wr_strobe=1.
- BUSY handshake after the command byte:
  - WAIT_BUSY_HI waits for bus_in[7]=1 before any operand byte is sent.
  - After the final write byte, WAIT_BUSY_LO waits for bus_in[7]=0.
  - For 0x22, WAIT_BUSY_HI is followed directly by WAIT_BUSY_LO, then RESPOND.
- Timeout: each wait state counts cycles. Exceeding TIMEOUT forces RESPOND with rsp_err=1, rsp_data=0, strobes low.
- Read byte sequence:
  - RD_HI: rd_strobe=1 for STROBE_HI cycles.
  - RD_LO: rd_strobe=0 for STROBE_LO cycles.
  - bus_in is sampled exactly RD_SAMPLE_DLY cycles after the rd_strobe rising edge, because the peripheral presents each byte for only one cycle.
  - Byte k is written to rsp_data[8k+7:8k]. Unread bytes are 0.
  - BUSY is not evaluated during reads.
- RESPOND: rsp_valid=1 for one cycle. rsp_data and rsp_err hold until the next acceptance. req_ready returns to 1 on the following cycle.
- Request during a transaction: req_valid while busy is ignored (no queueing). Only one strobe is ever high at a time.

Test Plan:
- Reset asserted mid WR_HI of opa MSB → next cycle: strobes 0, bus_out 0, req_ready 1, rsp_valid 0.
- Request cmd 0x20, opa=0x0180, opb=0x0200 with a peripheral model → WR bytes 0x20,0x80,0x01,0x00,0x02. Two RD strobes sample 0x00,0x03 → rsp_data=0x00000300, rsp_err=0.
- Request cmd 0x10, opa=0x0000 with the model returning bytes 0x00,0x01,0x00,0x00 → exactly 3 WR and 4 RD strobes, rsp_data=0x00000100.
- Request cmd 0x22 → 1 WR strobe (0x22), BUSY seen high then low, 0 RD strobes, rsp_valid with rsp_data=0, rsp_err=0.
- Request cmd 0x55 → no strobes; rsp_valid and rsp_err=1 one cycle after acceptance.
- Model holds BUSY=1 forever after cmd 0x21 → after TIMEOUT+1 cycles in WAIT_BUSY_LO: rsp_err=1, rd_strobe never asserted, req_ready returns to 1.
